// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage ready/valid register pipe with bubble collapse and synchronous flush; latency DEPTH-1 cycles
// after the accepting edge; ready chains combinationally back from io_deq_ready. PIPE_COUNT_EN adds the io_count port.
module elastic_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_enq_valid,
   output logic             io_enq_ready,
   input  logic [WIDTH-1:0] io_enq_bits,
   output logic             io_deq_valid,
   input  logic             io_deq_ready,
   output logic [WIDTH-1:0] io_deq_bits,
   input  logic             io_flush
`ifdef PIPE_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] io_count
`endif
);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] data [DEPTH];
   logic             free_chain;
   logic             enq_fire;

   // Walk from the tail toward stage 0: a stage advances when the one ahead is empty or itself advancing.
   always_comb begin
      adv        = '0;
      free_chain = io_deq_ready;
      for (int i = DEPTH-1; i >= 0; i--) begin
         adv[i]     = valid[i] && free_chain;
         free_chain = !valid[i] || adv[i];
      end
   end

   assign io_enq_ready = free_chain && !io_flush;
   assign enq_fire     = io_enq_valid && io_enq_ready;
   assign io_deq_valid = valid[DEPTH-1] && !io_flush;
   assign io_deq_bits  = data[DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
      end else if (io_flush) begin
         valid <= '0;
      end else begin
         valid[0] <= enq_fire || (valid[0] && !adv[0]);
         for (int i = 1; i < DEPTH; i++) begin
            valid[i] <= adv[i-1] || (valid[i] && !adv[i]);
         end
      end
   end

   // Data only moves with a live handshake/advance; a flush leaves stale data in place.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= '0;
         end
      end else if (!io_flush) begin
         if (enq_fire) begin
            data[0] <= io_enq_bits;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
               data[i] <= data[i-1];
            end
         end
      end
   end

`ifdef PIPE_COUNT_EN
   localparam int CW = $clog2(DEPTH+1);

   logic          deq_fire;
   logic [CW-1:0] count;

   assign deq_fire = io_deq_valid && io_deq_ready;
   assign io_count = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (io_flush) begin
         count <= '0;
      end else if (enq_fire && !deq_fire) begin
         count <= count + CW'(1);
      end else if (deq_fire && !enq_fire) begin
         count <= count - CW'(1);
      end
   end
`endif

endmodule
